// File: rtl/hazard_sequencer_pkg.sv
// rtl/hazard_sequencer_pkg.sv - shared widths and FSM encodings for the hazard sequencer
package hazard_sequencer_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int OPCODE_WIDTH = 6;
  localparam int HS_AWIDTH    = 5;

  typedef enum logic [1:0] {
    HS_RUN      = 2'd0,
    HS_REDIRECT = 2'd1,
    HS_MEM_WAIT = 2'd2
  } hs_state_e;

endpackage

// File: rtl/hazard_sequencer_detect.sv
// rtl/hazard_sequencer_detect.sv - combinational dependency, stall and MEM->ID forward equations
module hazard_detect #(
  parameter int AWIDTH = 5
) (
  input  logic [AWIDTH-1:0] ds_rs_i,
  input  logic [AWIDTH-1:0] ds_rt_i,
  input  logic              ds_use_rs_i,
  input  logic              ds_use_rt_i,
  input  logic              ds_branch_i,
  input  logic [AWIDTH-1:0] es_rd_i,
  input  logic              es_we_i,
  input  logic              es_mem_read_i,
  input  logic [AWIDTH-1:0] ms_rd_i,
  input  logic              ms_we_i,
  input  logic              ms_mem_read_i,
  output logic              hazard_o,
  output logic              fwd_rs_o,
  output logic              fwd_rt_o
);

  logic rs_live, rt_live;
  logic dep_es_rs, dep_es_rt, dep_ms_rs, dep_ms_rt;
  logic dep_es_any, dep_ms_any;
  logic load_use, branch_stall;

  // $zero is never a real producer, so it can never create a dependency
  assign rs_live = ds_use_rs_i && (ds_rs_i != '0);
  assign rt_live = ds_use_rt_i && (ds_rt_i != '0);

  assign dep_es_rs = rs_live && es_we_i && (es_rd_i == ds_rs_i);
  assign dep_es_rt = rt_live && es_we_i && (es_rd_i == ds_rt_i);
  assign dep_ms_rs = rs_live && ms_we_i && (ms_rd_i == ds_rs_i);
  assign dep_ms_rt = rt_live && ms_we_i && (ms_rd_i == ds_rt_i);

  assign dep_es_any = dep_es_rs || dep_es_rt;
  assign dep_ms_any = dep_ms_rs || dep_ms_rt;

  assign load_use     = dep_es_any && es_mem_read_i;
  // Branches compare in ID, so any EX producer or a MEM load is not yet available
  assign branch_stall = ds_branch_i && (dep_es_any || (dep_ms_any && ms_mem_read_i));

  assign hazard_o = load_use || branch_stall;
  assign fwd_rs_o = ds_branch_i && dep_ms_rs && !ms_mem_read_i;
  assign fwd_rt_o = ds_branch_i && dep_ms_rt && !ms_mem_read_i;

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - stall/flush/redirect FSM for the 5-stage pipeline
// Optional HAZARD_PERF_EN adds stall and flush event counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int AWIDTH = HS_AWIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [AWIDTH-1:0]   i_ds_rs,
  input  logic [AWIDTH-1:0]   i_ds_rt,
  input  logic                i_ds_use_rs,
  input  logic                i_ds_use_rt,
  input  logic                i_ds_branch,
  input  logic                i_ds_jump,
  input  logic                i_compare,
  input  logic [PC_WIDTH-1:0] i_target_pc,
  input  logic [AWIDTH-1:0]   i_es_rd,
  input  logic                i_es_we,
  input  logic                i_es_mem_read,
  input  logic [AWIDTH-1:0]   i_ms_rd,
  input  logic                i_ms_we,
  input  logic                i_ms_mem_read,
  input  logic                i_ms_ready,
  output logic                o_stall_fs,
  output logic                o_stall_ds,
  output logic                o_stall_es,
  output logic                o_stall_ms,
  output logic                o_flush_fs,
  output logic                o_flush_ds,
  output logic                o_fwd_rs,
  output logic                o_fwd_rt,
  output logic                o_change_pc,
  output logic [PC_WIDTH-1:0] o_pc
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         o_stall_cnt,
  output logic [31:0]         o_flush_cnt
`endif
);

  hs_state_e           state_q, state_d;
  logic                pend_q, pend_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                rst_q;
  logic                hazard, det_fwd_rs, det_fwd_rt;
  logic                taken, redirect_fire;

  hazard_detect #(.AWIDTH(AWIDTH)) u_detect (
    .ds_rs_i       (i_ds_rs),
    .ds_rt_i       (i_ds_rt),
    .ds_use_rs_i   (i_ds_use_rs),
    .ds_use_rt_i   (i_ds_use_rt),
    .ds_branch_i   (i_ds_branch),
    .es_rd_i       (i_es_rd),
    .es_we_i       (i_es_we),
    .es_mem_read_i (i_es_mem_read),
    .ms_rd_i       (i_ms_rd),
    .ms_we_i       (i_ms_we),
    .ms_mem_read_i (i_ms_mem_read),
    .hazard_o      (hazard),
    .fwd_rs_o      (det_fwd_rs),
    .fwd_rt_o      (det_fwd_rt)
  );

  assign taken = i_ds_jump || (i_ds_branch && i_compare);
  assign o_pc  = pc_q;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pc_d          = pc_q;
    o_stall_fs    = 1'b0;
    o_stall_ds    = 1'b0;
    o_stall_es    = 1'b0;
    o_stall_ms    = 1'b0;
    o_flush_fs    = 1'b0;
    o_flush_ds    = 1'b0;
    o_fwd_rs      = 1'b0;
    o_fwd_rt      = 1'b0;
    o_change_pc   = 1'b0;
    redirect_fire = 1'b0;

    unique case (state_q)
      HS_RUN: begin
        if (!i_ms_ready) begin
          {o_stall_fs, o_stall_ds, o_stall_es, o_stall_ms} = 4'b1111;
          state_d = HS_MEM_WAIT;
        end else begin
          o_stall_fs = hazard;
          o_stall_ds = hazard;
          o_flush_ds = hazard;
          o_fwd_rs   = det_fwd_rs;
          o_fwd_rt   = det_fwd_rt;
          if (taken && !hazard) begin
            pc_d    = i_target_pc;
            state_d = HS_REDIRECT;
          end
        end
      end
      HS_REDIRECT: begin
        if (!i_ms_ready) begin
          // Redirect is deferred, not lost: replayed once memory is ready
          {o_stall_fs, o_stall_ds, o_stall_es, o_stall_ms} = 4'b1111;
          pend_d  = 1'b1;
          state_d = HS_MEM_WAIT;
        end else begin
          o_change_pc   = 1'b1;
          o_flush_fs    = 1'b1;
          o_flush_ds    = 1'b1;
          redirect_fire = 1'b1;
          state_d       = HS_RUN;
        end
      end
      HS_MEM_WAIT: begin
        {o_stall_fs, o_stall_ds, o_stall_es, o_stall_ms} = 4'b1111;
        if (i_ms_ready) begin
          state_d = pend_q ? HS_REDIRECT : HS_RUN;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = HS_RUN;
        pend_d  = 1'b0;
      end
    endcase

    // No redirect or flush leaves the block during reset or the cycle after it
    if (i_rst || rst_q) begin
      o_change_pc   = 1'b0;
      o_flush_fs    = 1'b0;
      o_flush_ds    = 1'b0;
      redirect_fire = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HS_RUN;
      pend_q  <= 1'b0;
      pc_q    <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      rst_q   <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_stall_ds)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_fire) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ds_rs, ds_rt, es_rd, ms_rd;
  logic        use_rs, use_rt, branch, jump, compare;
  logic [31:0] target;
  logic        es_we, es_mr, ms_we, ms_mr, ready;
  logic        stall_fs, stall_ds, stall_es, stall_ms;
  logic        flush_fs, flush_ds, fwd_rs, fwd_rt, change_pc;
  logic [31:0] pc;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ds_rs       (ds_rs),
    .i_ds_rt       (ds_rt),
    .i_ds_use_rs   (use_rs),
    .i_ds_use_rt   (use_rt),
    .i_ds_branch   (branch),
    .i_ds_jump     (jump),
    .i_compare     (compare),
    .i_target_pc   (target),
    .i_es_rd       (es_rd),
    .i_es_we       (es_we),
    .i_es_mem_read (es_mr),
    .i_ms_rd       (ms_rd),
    .i_ms_we       (ms_we),
    .i_ms_mem_read (ms_mr),
    .i_ms_ready    (ready),
    .o_stall_fs    (stall_fs),
    .o_stall_ds    (stall_ds),
    .o_stall_es    (stall_es),
    .o_stall_ms    (stall_ms),
    .o_flush_fs    (flush_fs),
    .o_flush_ds    (flush_ds),
    .o_fwd_rs      (fwd_rs),
    .o_fwd_rt      (fwd_rt),
    .o_change_pc   (change_pc),
    .o_pc          (pc)
`ifdef HAZARD_PERF_EN
    ,
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear();
    ds_rs = 0; ds_rt = 0; use_rs = 0; use_rt = 0;
    branch = 0; jump = 0; compare = 0; target = 0;
    es_rd = 0; es_we = 0; es_mr = 0;
    ms_rd = 0; ms_we = 0; ms_mr = 0;
    ready = 1;
  endtask

  initial begin
    clear();
    rst = 1;
    tick(); tick();
    settle();
    check("rst_change_pc", {31'b0, change_pc}, 0);
    check("rst_pc", pc, 0);
    rst = 0;
    settle();
    check("idle_stall_ds", {31'b0, stall_ds}, 0);
    tick();

    // load-use: EX lw $t1(9), ID add uses $t1
    es_rd = 9; es_we = 1; es_mr = 1; ds_rs = 9; use_rs = 1;
    settle();
    check("lu_stall_fs", {31'b0, stall_fs}, 1);
    check("lu_stall_ds", {31'b0, stall_ds}, 1);
    check("lu_flush_ds", {31'b0, flush_ds}, 1);
    check("lu_stall_es", {31'b0, stall_es}, 0);
    tick();
    es_rd = 0; es_we = 0; es_mr = 0; ms_rd = 9; ms_we = 1; ms_mr = 1;
    settle();
    check("lu_issue_stall", {31'b0, stall_ds}, 0);
    check("lu_issue_flush", {31'b0, flush_ds}, 0);
    tick(); clear();

    // branch after ALU in MEM: forward rs, no stall, not taken
    ms_rd = 10; ms_we = 1; branch = 1; ds_rs = 10; ds_rt = 11; use_rs = 1; use_rt = 1;
    settle();
    check("fwd_rs", {31'b0, fwd_rs}, 1);
    check("fwd_rt", {31'b0, fwd_rt}, 0);
    check("fwd_no_stall", {31'b0, stall_ds}, 0);
    tick(); clear(); settle();
    check("nt_change_pc", {31'b0, change_pc}, 0);

    // branch after load: two stall cycles, then redirect to 0x40
    es_rd = 9; es_we = 1; es_mr = 1;
    branch = 1; compare = 1; target = 32'h40; ds_rs = 9; ds_rt = 0; use_rs = 1; use_rt = 1;
    settle();
    check("bl_stall1", {31'b0, stall_ds}, 1);
    check("bl_flush1", {31'b0, flush_ds}, 1);
    tick();
    es_rd = 0; es_we = 0; es_mr = 0; ms_rd = 9; ms_we = 1; ms_mr = 1;
    settle();
    check("bl_stall2", {31'b0, stall_ds}, 1);
    check("bl_fwd_load", {31'b0, fwd_rs}, 0);
    tick();
    ms_rd = 0; ms_we = 0; ms_mr = 0;
    settle();
    check("bl_stall3", {31'b0, stall_ds}, 0);
    check("bl_no_early_redirect", {31'b0, change_pc}, 0);
    tick(); clear(); settle();
    check("bl_change_pc", {31'b0, change_pc}, 1);
    check("bl_pc", pc, 32'h40);
    check("bl_flush_fs", {31'b0, flush_fs}, 1);
    tick(); settle();
    check("bl_change_pc_off", {31'b0, change_pc}, 0);

    // jump with $zero dependencies that must not stall
    es_rd = 0; es_we = 1; es_mr = 1; ds_rs = 0; use_rs = 1;
    jump = 1; target = 32'h100;
    settle();
    check("j_zero_no_stall", {31'b0, stall_ds}, 0);
    tick(); clear(); settle();
    check("j_change_pc", {31'b0, change_pc}, 1);
    check("j_flush_fs", {31'b0, flush_fs}, 1);
    check("j_flush_ds", {31'b0, flush_ds}, 1);
    check("j_pc", pc, 32'h100);
    tick(); settle();
    check("j_change_off", {31'b0, change_pc}, 0);
    check("j_flush_fs_off", {31'b0, flush_fs}, 0);
    check("j_pc_hold", pc, 32'h100);

    // memory wait during redirect
    jump = 1; target = 32'h200;
    tick(); clear(); ready = 0; settle();
    check("mw_change_sup", {31'b0, change_pc}, 0);
    check("mw_flush_sup", {31'b0, flush_fs}, 0);
    check("mw_stall_ms", {31'b0, stall_ms}, 1);
    check("mw_stall_fs", {31'b0, stall_fs}, 1);
    tick(); settle();
    check("mw_wait_stall_es", {31'b0, stall_es}, 1);
    tick(); settle();
    check("mw_wait_change", {31'b0, change_pc}, 0);
    tick(); ready = 1; settle();
    check("mw_ret_stall_ms", {31'b0, stall_ms}, 1);
    check("mw_ret_change", {31'b0, change_pc}, 0);
    tick(); settle();
    check("mw_redirect", {31'b0, change_pc}, 1);
    check("mw_pc", pc, 32'h200);
    tick(); settle();
    check("mw_run_stall_ms", {31'b0, stall_ms}, 0);

    // ready drop in RUN overrides a hazard
    es_rd = 9; es_we = 1; es_mr = 1; ds_rs = 9; use_rs = 1; ready = 0;
    settle();
    check("drop_stall_es", {31'b0, stall_es}, 1);
    check("drop_no_flush", {31'b0, flush_ds}, 0);
    tick(); clear(); settle();
    check("drop_ret_stall_ms", {31'b0, stall_ms}, 1);
    tick(); settle();
    check("drop_run_stall_ms", {31'b0, stall_ms}, 0);

    // reset while in MEM_WAIT with a pending redirect
    jump = 1; target = 32'h300;
    tick(); clear(); ready = 0; settle();
    check("rw_change_sup", {31'b0, change_pc}, 0);
    tick();
    rst = 1; settle();
    check("rw_rst_change", {31'b0, change_pc}, 0);
    tick();
    rst = 0; ready = 1;
    es_rd = 9; es_we = 1; es_mr = 1; ds_rs = 9; use_rs = 1;
    settle();
    check("rw_pc", pc, 0);
    check("rw_change", {31'b0, change_pc}, 0);
    check("rw_stall_ms", {31'b0, stall_ms}, 0);
    check("rw_stall_ds", {31'b0, stall_ds}, 1);
    check("rw_flush_gated", {31'b0, flush_ds}, 0);
`ifdef HAZARD_PERF_EN
    check("rw_stall_cnt", stall_cnt, 0);
    check("rw_flush_cnt", flush_cnt, 0);
`endif
    tick(); settle();
    check("rw_no_redirect", {31'b0, change_pc}, 0);
    check("rw_flush_live", {31'b0, flush_ds}, 1);
`ifdef HAZARD_PERF_EN
    check("rw_stall_cnt_inc", stall_cnt, 1);
`endif
    tick(); clear(); settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
